// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage : instruction-fetch stage plus IF/ID pipeline register.
//
// Holds the fetch PC and drives a single-outstanding request/ack instruction
// bus. The IF/ID slot is presented to decode as {if_pc_o, if_insn_o, if_en_o}.
// Stall, flush and branch redirect are handled with the priority
// rst_i > flush_i > (br_taken_i & ~stall_i) > normal fetch.
//
// Ports
//   clk_i, rst_i              clock, synchronous active-high reset
//   bus_req_o / bus_addr_o    fetch request and word address (combinational)
//   bus_ack_i / bus_rdata_i   fetch completion and instruction data
//   stall_i                   hold the IF/ID register
//   flush_i / new_pc_i        discard everything and restart at new_pc_i
//   br_taken_i / br_addr_i    taken branch from decode and its target
//   busy_o                    request outstanding and not acked this cycle
//   if_pc_o/if_insn_o/if_en_o IF/ID slot
//   if_bus_err_o              IF/ID slot carries a fetch-timeout exception
//
// Optional build macro IF_BUS_TIMEOUT_EN adds a fetch timeout counter and an
// ERR state; without it FETCH waits indefinitely and if_bus_err_o stays 0.
// -----------------------------------------------------------------------------
module if_stage #(
    parameter int unsigned                IF_ADD_WIDTH = 30,
    parameter int unsigned                IF_DAT_WIDTH = 32,
    parameter logic [IF_ADD_WIDTH-1:0]    RESET_VECTOR = {IF_ADD_WIDTH{1'b0}},
    parameter logic [IF_DAT_WIDTH-1:0]    NOP_INSN     = {IF_DAT_WIDTH{1'b0}},
    parameter int unsigned                TIMEOUT_CYC  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    output logic                    bus_req_o,
    output logic [IF_ADD_WIDTH-1:0] bus_addr_o,
    input  logic                    bus_ack_i,
    input  logic [IF_DAT_WIDTH-1:0] bus_rdata_i,
    input  logic                    stall_i,
    input  logic                    flush_i,
    input  logic [IF_ADD_WIDTH-1:0] new_pc_i,
    input  logic                    br_taken_i,
    input  logic [IF_ADD_WIDTH-1:0] br_addr_i,
    output logic                    busy_o,
    output logic [IF_ADD_WIDTH-1:0] if_pc_o,
    output logic [IF_DAT_WIDTH-1:0] if_insn_o,
    output logic                    if_en_o,
    output logic                    if_bus_err_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HELD  = 2'd2;
    localparam logic [1:0] ST_ERR   = 2'd3;

    localparam logic [IF_ADD_WIDTH-1:0] PC_ONE = {{(IF_ADD_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]              state_r;
    logic [IF_ADD_WIDTH-1:0] fetch_pc_r;
    logic [IF_ADD_WIDTH-1:0] if_pc_r;
    logic [IF_DAT_WIDTH-1:0] if_insn_r;
    logic                    if_en_r;
    logic                    if_bus_err_r;
    logic [IF_ADD_WIDTH-1:0] buf_pc_r;
    logic [IF_DAT_WIDTH-1:0] buf_insn_r;
    logic                    buf_valid_r;
    logic                    br_take_s;
    logic                    tmo_hit_s;

    // A bus-error slot can only be left through a flush, so branches are
    // ignored in ERR; elsewhere a stalled branch is dropped.
    assign br_take_s    = br_taken_i & ~stall_i & (state_r != ST_ERR);

    assign bus_req_o    = (state_r == ST_FETCH);
    assign bus_addr_o   = fetch_pc_r;
    assign busy_o       = bus_req_o & ~bus_ack_i;
    assign if_pc_o      = if_pc_r;
    assign if_insn_o    = if_insn_r;
    assign if_en_o      = if_en_r;
    assign if_bus_err_o = if_bus_err_r;

`ifdef IF_BUS_TIMEOUT_EN
    localparam int unsigned        TMO_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0]   TMO_MAX = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [TMO_W-1:0]   TMO_ONE = TMO_W'(1);

    logic [TMO_W-1:0] tmo_cnt_r;

    // Timeout fires on the TIMEOUT_CYC-th consecutive unacked fetch cycle.
    always_comb begin
        tmo_hit_s = 1'b0;
        if ((state_r == ST_FETCH) && !bus_ack_i && !stall_i && (tmo_cnt_r == TMO_MAX)) begin
            tmo_hit_s = 1'b1;
        end else begin
            tmo_hit_s = 1'b0;
        end
    end

    // Count unacked fetch cycles; saturates so a long stall cannot wrap it.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i || br_take_s) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else if (state_r != ST_FETCH || bus_ack_i) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else if (tmo_cnt_r != TMO_MAX) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end
`else
    assign tmo_hit_s = 1'b0;

    // Timeout limit only matters in the timeout build; this keeps the
    // parameter referenced so both builds share one instantiation interface.
    if (TIMEOUT_CYC == 0) begin : g_tmo_unused
    end
`endif

    // Fetch state machine, fetch PC, one-entry stall buffer and IF/ID slot.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r      <= ST_IDLE;
            fetch_pc_r   <= RESET_VECTOR;
            if_pc_r      <= RESET_VECTOR;
            if_insn_r    <= NOP_INSN;
            if_en_r      <= 1'b0;
            if_bus_err_r <= 1'b0;
            buf_pc_r     <= RESET_VECTOR;
            buf_insn_r   <= NOP_INSN;
            buf_valid_r  <= 1'b0;
        end else if (flush_i || br_take_s) begin
            // Redirect: any ack arriving this cycle belongs to the old stream.
            state_r      <= ST_FETCH;
            fetch_pc_r   <= flush_i ? new_pc_i : br_addr_i;
            if_insn_r    <= NOP_INSN;
            if_en_r      <= 1'b0;
            if_bus_err_r <= 1'b0;
            buf_valid_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (bus_ack_i) begin
                        fetch_pc_r <= fetch_pc_r + PC_ONE;
                        if (stall_i) begin
                            // Decode cannot take it yet: park it and stop fetching.
                            buf_pc_r    <= fetch_pc_r;
                            buf_insn_r  <= bus_rdata_i;
                            buf_valid_r <= 1'b1;
                            state_r     <= ST_HELD;
                        end else begin
                            if_pc_r      <= fetch_pc_r;
                            if_insn_r    <= bus_rdata_i;
                            if_en_r      <= 1'b1;
                            if_bus_err_r <= 1'b0;
                        end
                    end else if (tmo_hit_s) begin
                        if_pc_r      <= fetch_pc_r;
                        if_insn_r    <= NOP_INSN;
                        if_en_r      <= 1'b1;
                        if_bus_err_r <= 1'b1;
                        state_r      <= ST_ERR;
                    end else if (!stall_i) begin
                        if_insn_r    <= NOP_INSN;
                        if_en_r      <= 1'b0;
                        if_bus_err_r <= 1'b0;
                    end else begin
                        state_r <= ST_FETCH;
                    end
                end
                ST_HELD: begin
                    if (!stall_i) begin
                        if_pc_r      <= buf_pc_r;
                        if_insn_r    <= buf_insn_r;
                        if_en_r      <= buf_valid_r;
                        if_bus_err_r <= 1'b0;
                        buf_valid_r  <= 1'b0;
                        state_r      <= ST_FETCH;
                    end else begin
                        state_r <= ST_HELD;
                    end
                end
`ifdef IF_BUS_TIMEOUT_EN
                ST_ERR: begin
                    // Error slot is consumed once decode is free; then idle in ERR.
                    if (!stall_i) begin
                        if_insn_r    <= NOP_INSN;
                        if_en_r      <= 1'b0;
                        if_bus_err_r <= 1'b0;
                    end else begin
                        state_r <= ST_ERR;
                    end
                end
`endif
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        bus_req_o;
    logic [29:0] bus_addr_o;
    logic        bus_ack_i = 1'b0;
    logic [31:0] bus_rdata_i = 32'd0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [29:0] new_pc_i = 30'd0;
    logic        br_taken_i = 1'b0;
    logic [29:0] br_addr_i = 30'd0;
    logic        busy_o;
    logic [29:0] if_pc_o;
    logic [31:0] if_insn_o;
    logic        if_en_o;
    logic        if_bus_err_o;

    int n_tests = 0;
    int n_fail  = 0;

    if_stage dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .bus_req_o(bus_req_o), .bus_addr_o(bus_addr_o),
        .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
        .stall_i(stall_i), .flush_i(flush_i), .new_pc_i(new_pc_i),
        .br_taken_i(br_taken_i), .br_addr_i(br_addr_i),
        .busy_o(busy_o),
        .if_pc_o(if_pc_o), .if_insn_o(if_insn_o), .if_en_o(if_en_o),
        .if_bus_err_o(if_bus_err_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: what the fetch unit is doing, where it fetches next,
    // what decode sees, and the single parked instruction.
    typedef enum int {M_START, M_FETCHING, M_PARKED, M_FAULTED} mode_t;
    mode_t       m_mode = M_START;
    bit          m_known = 0;
    logic [29:0] m_next;
    logic [29:0] m_pc;
    logic [31:0] m_insn;
    logic        m_en;
    logic        m_err;
    logic [29:0] m_park_pc;
    logic [31:0] m_park_insn;
    int          m_unacked;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_of(input logic [29:0] a);
        return 32'h1000_0000 + 32'(a);
    endfunction

    function automatic void slot_bubble();
        m_en   = 1'b0;
        m_insn = 32'd0;
        m_err  = 1'b0;
    endfunction

    function automatic void model_edge(input bit rst, ack, stall, flush, br,
                                       input logic [29:0] npc, baddr,
                                       input logic [31:0] rdata);
        if (rst) begin
            m_mode = M_START; m_next = 30'd0; m_pc = 30'd0;
            m_unacked = 0; m_known = 1;
            slot_bubble();
        end else if (flush) begin
            m_mode = M_FETCHING; m_next = npc; m_unacked = 0;
            slot_bubble();
        end else if (br && !stall && m_mode != M_FAULTED) begin
            m_mode = M_FETCHING; m_next = baddr; m_unacked = 0;
            slot_bubble();
        end else if (m_mode == M_START) begin
            m_mode = M_FETCHING;
        end else if (m_mode == M_FETCHING) begin
            if (ack) begin
                m_unacked = 0;
                if (stall) begin
                    m_park_pc = m_next; m_park_insn = rdata; m_mode = M_PARKED;
                end else begin
                    m_pc = m_next; m_insn = rdata; m_en = 1'b1; m_err = 1'b0;
                end
                m_next = m_next + 30'd1;
            end else begin
                m_unacked++;
`ifdef IF_BUS_TIMEOUT_EN
                if (m_unacked >= 16 && !stall) begin
                    m_pc = m_next; m_insn = 32'd0; m_en = 1'b1; m_err = 1'b1;
                    m_mode = M_FAULTED;
                end else if (!stall) slot_bubble();
`else
                if (!stall) slot_bubble();
`endif
            end
        end else if (m_mode == M_PARKED) begin
            if (!stall) begin
                m_pc = m_park_pc; m_insn = m_park_insn; m_en = 1'b1; m_err = 1'b0;
                m_mode = M_FETCHING;
            end
        end else begin
            if (!stall) slot_bubble();
        end
    endfunction

    // One clock: drive inputs after the falling edge, compare against the
    // model, then advance the model at the rising edge.
    task automatic step(input bit rst, ack, stall, flush, br,
                        input logic [29:0] npc, baddr, input logic [31:0] rdata);
        logic exp_req;
        @(negedge clk_i);
        rst_i = rst; bus_ack_i = ack; stall_i = stall; flush_i = flush;
        br_taken_i = br; new_pc_i = npc; br_addr_i = baddr; bus_rdata_i = rdata;
        #1;
        if (m_known) begin
            exp_req = (m_mode == M_FETCHING);
            chk("req",  32'(bus_req_o),   32'(exp_req));
            chk("addr", 32'(bus_addr_o),  32'(m_next));
            chk("busy", 32'(busy_o),      32'(exp_req & ~ack));
            chk("pc",   32'(if_pc_o),     32'(m_pc));
            chk("insn", if_insn_o,        m_insn);
            chk("en",   32'(if_en_o),     32'(m_en));
            chk("err",  32'(if_bus_err_o), 32'(m_err));
        end
        @(posedge clk_i);
        model_edge(rst, ack, stall, flush, br, npc, baddr, rdata);
        #1;
    endtask

    task automatic fetch(input bit ack, stall);
        step(1'b0, ack, stall, 1'b0, 1'b0, 30'd0, 30'd0, rd_of(m_next));
    endtask

    initial begin
        // 1: reset, then ack every cycle
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 30'd0, 30'd0, 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 30'd0, 30'd0, 32'd0);
        chk("rst_en",   32'(if_en_o), 32'd0);
        chk("rst_insn", if_insn_o,    32'd0);
        chk("rst_req",  32'(bus_req_o), 32'd0);
        fetch(1'b1, 1'b0);                      // IDLE cycle, ack ignored
        chk("t1_addr0", 32'(bus_addr_o), 32'd0);
        chk("t1_req",   32'(bus_req_o),  32'd1);
        fetch(1'b1, 1'b0);
        chk("t1_pc0",   32'(if_pc_o), 32'd0);
        chk("t1_insn0", if_insn_o,    32'h1000_0000);
        chk("t1_en0",   32'(if_en_o), 32'd1);
        fetch(1'b1, 1'b0);
        fetch(1'b1, 1'b0);
        chk("t1_pc2",   32'(if_pc_o), 32'd2);
        chk("t1_insn2", if_insn_o,    32'h1000_0002);
        // 2: ack at pc=5 while stalled for 3 cycles
        fetch(1'b1, 1'b0);
        fetch(1'b1, 1'b0);
        fetch(1'b1, 1'b1);
        chk("t2_hold_pc", 32'(if_pc_o),   32'd4);
        chk("t2_req0",    32'(bus_req_o), 32'd0);
        fetch(1'b0, 1'b1);
        fetch(1'b0, 1'b1);
        chk("t2_still",   32'(if_pc_o),   32'd4);
        fetch(1'b0, 1'b0);
        chk("t2_pc5",     32'(if_pc_o),   32'd5);
        chk("t2_insn5",   if_insn_o,      32'h1000_0005);
        chk("t2_addr6",   32'(bus_addr_o), 32'd6);
        // 3: branch taken while pc=8 is acked
        fetch(1'b1, 1'b0);
        fetch(1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 30'd0, 30'h100, rd_of(m_next));
        chk("t3_en",   32'(if_en_o),    32'd0);
        chk("t3_addr", 32'(bus_addr_o), 32'h100);
        // 4: flush beats a stalled branch
        fetch(1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 30'h3F0, 30'h200, rd_of(m_next));
        chk("t4_addr", 32'(bus_addr_o), 32'h3F0);
        chk("t4_en",   32'(if_en_o),    32'd0);
        chk("t4_req",  32'(bus_req_o),  32'd1);
        // 5: fetch address wraps
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 30'h3FFF_FFFF, 30'd0, 32'd0);
        fetch(1'b1, 1'b0);
        chk("t5_addr", 32'(bus_addr_o), 32'd0);
        chk("t5_pc",   32'(if_pc_o),    32'h3FFF_FFFF);
`ifdef IF_BUS_TIMEOUT_EN
        // 6: fetch timeout at 0x20
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 30'h20, 30'd0, 32'd0);
        for (int i = 0; i < 16; i++) fetch(1'b0, 1'b0);
        chk("t6_en",  32'(if_en_o),      32'd1);
        chk("t6_err", 32'(if_bus_err_o), 32'd1);
        chk("t6_pc",  32'(if_pc_o),      32'h20);
        chk("t6_req", 32'(bus_req_o),    32'd0);
        for (int i = 0; i < 3; i++) fetch(1'b1, 1'b0);
        chk("t6_req_err", 32'(bus_req_o), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 30'h40, 30'd0, 32'd0);
        chk("t6_recover", 32'(bus_req_o), 32'd1);
`endif
        // 7: reset mid-fetch, late ack ignored
        fetch(1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 30'd0, 30'd0, 32'hDEAD_BEEF);
        fetch(1'b1, 1'b0);
        chk("t7_en", 32'(if_en_o), 32'd0);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(199) == 0,
                 $urandom_range(99) < 60,
                 $urandom_range(99) < 30,
                 $urandom_range(99) < 3,
                 $urandom_range(99) < 6,
                 30'($urandom), 30'($urandom), $urandom);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register. Sits directly upstream of the instruction decode stage.
- Holds the fetch PC and drives a single-outstanding request/ack instruction bus.
- Presents {pc, insn, en} to decode and honours stall, flush and branch redirect from the pipeline controller and decode.

Parameters:
IF_ADD_WIDTH, 30, word-address width of PC and bus address
IF_DAT_WIDTH, 32, instruction width
RESET_VECTOR, 0, fetch PC after reset (word address)
NOP_INSN, 0, instruction value driven when the slot is invalid
TIMEOUT_CYC, 16, bus timeout limit in cycles (used only with the optional feature)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
bus_req_o  out  1  fetch request
bus_addr_o  out  IF_ADD_WIDTH  fetch word address
bus_ack_i  in  1  data valid for the current request
bus_rdata_i  in  IF_DAT_WIDTH  fetched instruction
stall_i  in  1  hold IF/ID register (pipeline controller)
flush_i  in  1  discard all and redirect to new_pc_i
new_pc_i  in  IF_ADD_WIDTH  exception/return redirect target
br_taken_i  in  1  branch taken (from decode)
br_addr_i  in  IF_ADD_WIDTH  branch target
busy_o  out  1  bus_req_o & ~bus_ack_i (fetch wait, to controller)
if_pc_o  out  IF_ADD_WIDTH  IF/ID pc
if_insn_o  out  IF_DAT_WIDTH  IF/ID instruction
if_en_o  out  1  IF/ID valid
if_bus_err_o  out  1  IF/ID slot carries a fetch-timeout exception

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst_i=1 at an edge) sets the following:
  - state=IDLE, fetch_pc=RESET_VECTOR
  - if_pc_o=RESET_VECTOR, if_insn_o=NOP_INSN, if_en_o=0, if_bus_err_o=0
  - buffer empty, timeout counter=0
- Combinational outputs: bus_req_o=1 only in FETCH; bus_addr_o=fetch_pc.
- Reset asserted mid-fetch abandons the request. A late ack is ignored (state is not FETCH).
- States and transitions:
  - IDLE: unconditionally to FETCH next cycle. Sole purpose is the reset-release cycle.
  - FETCH, ack, no stall: IF/ID <= {fetch_pc, bus_rdata_i, en=1}; fetch_pc+1; stay in FETCH. Latency: ack in cycle n gives if_en_o=1 in cycle n+1. Back-to-back acks give one instruction per cycle.
  - FETCH, ack, stall: IF/ID held; {fetch_pc, rdata} captured into a 1-entry buffer; fetch_pc+1; go to HELD.
  - FETCH, no ack, no stall: IF/ID <= bubble (en=0, insn=NOP_INSN, pc unchanged).
  - FETCH, no ack, stall: IF/ID held.
  - HELD: bus_req_o=0. When stall_i=0: IF/ID <= buffer, en=1; go to FETCH.
- Priority at any edge: rst_i > flush_i > br_taken_i&~stall_i > normal operation.
- flush_i:
  - fetch_pc <= new_pc_i; IF/ID <= bubble; buffer cleared; timeout counter cleared; state <= FETCH.
  - An ack in the same cycle is discarded.
  - stall_i is ignored while flush_i=1.
- br_taken_i with stall_i=0:
  - fetch_pc <= br_addr_i; IF/ID <= bubble; buffer cleared; state <= FETCH.
  - An ack in the same cycle is discarded (no delay slot).
- br_taken_i with stall_i=1: ignored.
- fetch_pc increments modulo 2^IF_ADD_WIDTH; all-ones wraps to 0.
- if_bus_err_o=0 always unless the optional feature is compiled in.

Optional Feature:
- Macro IF_BUS_TIMEOUT_EN.
- Defined:
  - Counter increments each FETCH cycle with bus_ack_i=0 and clears on ack/flush/branch.
  - When it reaches TIMEOUT_CYC-1 with no ack and stall_i=0: IF/ID <= {fetch_pc, NOP_INSN, en=1, bus_err=1}; state <= ERR (bus_req_o=0).
  - In ERR, all acks are ignored.
  - From ERR, the following cycle loads a bubble into IF/ID; stay in ERR until flush_i, which proceeds as a normal flush.
- Undefined: no counter or ERR state; FETCH waits indefinitely; if_bus_err_o tied 0.

Test Plan:
1. Release reset; ack every cycle, rdata=0x1000_0000+addr -> first bus_addr_o=0; if_pc_o=0,1,2 with if_insn_o=0x1000_0000,0x1000_0001,0x1000_0002; if_en_o=1 from cycle after first ack.
2. Ack at pc=5 while stall_i=1 for 3 cycles -> IF/ID holds pc=4; bus_req_o=0 during HELD; on stall release, if_pc_o=5 with the buffered insn; next bus_addr_o=6.
3. br_taken_i=1, br_addr_i=0x100 while ack for pc=8 -> pc=8 insn dropped; if_en_o=0 next cycle; next bus_addr_o=0x100.
4. flush_i=1, new_pc_i=0x3F0 concurrent with br_taken_i=1 and stall_i=1 -> bus_addr_o=0x3F0 next cycle; if_en_o=0; buffer empty.
5. fetch_pc=0x3FFF_FFFF acked -> next bus_addr_o=0; if_pc_o=0x3FFF_FFFF.
6. IF_BUS_TIMEOUT_EN, no ack for 16 cycles at pc=0x20 -> if_en_o=1, if_bus_err_o=1, if_insn_o=NOP_INSN, if_pc_o=0x20; bus_req_o=0 until flush_i.
